// File: rtl/invader_march_ctrl.sv
// Alien formation march controller: paces steps off the upstream tick counter and moves the formation in a serpentine path until it lands.
// Optional macro MARCH_SPEEDUP_EN shortens the step period by one tick per completed drop.
module invader_march_ctrl #(
    parameter int X_W       = 6,
    parameter int Y_W       = 5,
    parameter int X_MAX     = 40,
    parameter int Y_MAX     = 20,
    parameter int STEP_X    = 1,
    parameter int DROP_ROWS = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           start,
    input  logic [4:0]     period,
    input  logic [4:0]     currCount,
    output logic           counterClr,
    output logic           stepPulse,
    output logic [X_W-1:0] xOffset,
    output logic [Y_W-1:0] yOffset,
    output logic           dirLeft,
    output logic           landed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARCH,
        S_DROP,
        S_LANDED
    } state_t;

    localparam logic [X_W:0]   X_LIMIT = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]   X_STEP  = (X_W+1)'(STEP_X);
    localparam logic [Y_W:0]   Y_LIMIT = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0]   Y_STEP  = (Y_W+1)'(DROP_ROWS);
    localparam logic [Y_W-1:0] Y_SAT   = Y_W'(Y_MAX);

    state_t       state;
    logic         holdoff;
    logic [4:0]   eff_period;
    logic         step_event;
    logic [X_W:0] x_wide;
    logic [X_W:0] x_right;
    logic         right_ok;
    logic         left_ok;
    logic [Y_W:0] y_sum;
    logic [Y_W-1:0] y_next;
    logic         y_done;

`ifdef MARCH_SPEEDUP_EN
    logic [4:0] dropCount;

    // Each completed drop shaves one tick off the period, never below one tick.
    always_comb begin
        eff_period = 5'd1;
        if (period > dropCount && (period - dropCount) > 5'd1)
            eff_period = period - dropCount;
    end
`else
    always_comb begin
        eff_period = (period == 5'd0) ? 5'd1 : period;
    end
`endif

    // Holdoff masks the compare for the cycle after a step, while the counter clear is still in flight.
    assign step_event = enable && !holdoff
                     && (state == S_MARCH || state == S_DROP)
                     && (currCount >= eff_period);

    // One extra bit keeps the edge compare honest when x sits near the top of its range.
    assign x_wide   = {1'b0, xOffset};
    assign x_right  = x_wide + X_STEP;
    assign right_ok = (x_right <= X_LIMIT);
    assign left_ok  = (x_wide >= X_STEP);

    assign y_sum  = {1'b0, yOffset} + Y_STEP;
    assign y_done = (y_sum >= Y_LIMIT);
    assign y_next = y_done ? Y_SAT : y_sum[Y_W-1:0];

    // NOTE: every register here uses non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            xOffset    <= '0;
            yOffset    <= '0;
            dirLeft    <= 1'b0;
            stepPulse  <= 1'b0;
            landed     <= 1'b0;
            counterClr <= 1'b1;
            holdoff    <= 1'b0;
`ifdef MARCH_SPEEDUP_EN
            dropCount  <= 5'd0;
`endif
        end else begin
            stepPulse <= 1'b0;
            holdoff   <= 1'b0;
            if (!enable) begin
                // Frozen: keep the counter parked only where it is always parked.
                counterClr <= (state == S_IDLE || state == S_LANDED);
            end else begin
                case (state)
                    S_IDLE: begin
                        counterClr <= 1'b1;
                        if (start) begin
                            state      <= S_MARCH;
                            counterClr <= 1'b0;
                        end
                    end
                    S_MARCH, S_DROP: begin
                        stepPulse  <= step_event;
                        counterClr <= step_event;
                        holdoff    <= step_event;
                        if (step_event) begin
                            if (state == S_MARCH) begin
                                if (!dirLeft && right_ok)
                                    xOffset <= x_right[X_W-1:0];
                                else if (dirLeft && left_ok)
                                    xOffset <= xOffset - X_STEP[X_W-1:0];
                                else
                                    state <= S_DROP;
                            end else begin
                                yOffset <= y_next;
                                dirLeft <= ~dirLeft;
`ifdef MARCH_SPEEDUP_EN
                                if (dropCount != 5'd31)
                                    dropCount <= dropCount + 5'd1;
`endif
                                if (y_done) begin
                                    state  <= S_LANDED;
                                    landed <= 1'b1;
                                end else begin
                                    state <= S_MARCH;
                                end
                            end
                        end
                    end
                    S_LANDED: begin
                        counterClr <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Bench for invader_march_ctrl: a free-running tick counter cleared by counterClr, a rule-level formation model
// compared every cycle, and directed checks pinning the step cadence, edges, freeze, landing and async reset.
module tb_invader_march_ctrl;

    localparam int X_MAX     = 40;
    localparam int Y_MAX     = 20;
    localparam int STEP_X    = 1;
    localparam int DROP_ROWS = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [4:0] period = 5'd3;
    logic [4:0] cnt;
    logic       counterClr, stepPulse, dirLeft, landed;
    logic [5:0] xOffset;
    logic [4:0] yOffset;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    invader_march_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .period    (period),
        .currCount (cnt),
        .counterClr(counterClr),
        .stepPulse (stepPulse),
        .xOffset   (xOffset),
        .yOffset   (yOffset),
        .dirLeft   (dirLeft),
        .landed    (landed)
    );

    // Upstream tick counter: free-running, saturating, cleared whenever the controller asks.
    always @(posedge clk or negedge rst) begin
        if (!rst)            cnt <= 5'd0;
        else if (counterClr) cnt <= 5'd0;
        else if (cnt != 5'd31) cnt <= cnt + 5'd1;
    end

    // Formation model in game terms: running / drop pending / landed flags and integer offsets.
    bit m_running = 0, m_drop_pending = 0, m_landed = 0, m_left = 0;
    bit m_pulse = 0, m_clr = 1, m_hold = 0;
    int m_x = 0, m_y = 0, m_drops = 0;

    function automatic int eff_period(int p, int drops);
`ifdef MARCH_SPEEDUP_EN
        return (p - drops < 1) ? 1 : p - drops;
`else
        return (p < 1) ? 1 : p;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_running = 0; m_drop_pending = 0; m_landed = 0; m_left = 0;
            m_pulse = 0; m_clr = 1; m_hold = 0;
            m_x = 0; m_y = 0; m_drops = 0;
        end else if (!enable) begin
            m_pulse = 0;
            m_hold  = 0;
            m_clr   = !m_running;
        end else if (m_landed) begin
            m_pulse = 0;
            m_clr   = 1;
        end else if (!m_running) begin
            m_pulse = 0;
            m_clr   = 1;
            if (start) begin
                m_running = 1;
                m_clr     = 0;
            end
        end else begin
            bit fire;
            int target;
            fire    = !m_hold && (int'(cnt) >= eff_period(int'(period), m_drops));
            m_pulse = fire;
            m_clr   = fire;
            m_hold  = fire;
            if (fire) begin
                if (m_drop_pending) begin
                    m_y = (m_y + DROP_ROWS > Y_MAX) ? Y_MAX : m_y + DROP_ROWS;
                    m_left = !m_left;
                    m_drop_pending = 0;
                    if (m_drops < 31) m_drops++;
                    if (m_y >= Y_MAX) begin
                        m_landed  = 1;
                        m_running = 0;
                    end
                end else begin
                    target = m_left ? m_x - STEP_X : m_x + STEP_X;
                    if (target >= 0 && target <= X_MAX) m_x = target;
                    else m_drop_pending = 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            check("m_xOffset",    int'(xOffset),    m_x);
            check("m_yOffset",    int'(yOffset),    m_y);
            check("m_dirLeft",    int'(dirLeft),    int'(m_left));
            check("m_stepPulse",  int'(stepPulse),  int'(m_pulse));
            check("m_counterClr", int'(counterClr), int'(m_clr));
            check("m_landed",     int'(landed),     int'(m_landed));
        end
    end

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!stepPulse && cyc < 200);
        if (!stepPulse) check("pulse_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int c;
        int npulse;
        int nclr0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_counterClr", int'(counterClr), 1);
        check("rst_stepPulse",  int'(stepPulse),  0);
        check("rst_xOffset",    int'(xOffset),    0);
        check("rst_landed",     int'(landed),     0);

        enable = 1'b1;
        period = 5'd3;
        pulse_start();
        check("start_clr_low", int'(counterClr), 0);

        wait_pulse(c);
        check("first_x", int'(xOffset), 1);
        wait_pulse(c);
        check("interval_a", c, 5);
        check("second_x", int'(xOffset), 2);
        wait_pulse(c);
        check("interval_b", c, 5);

        // Async reset mid-march at x=17, checked before any clock edge.
        for (int k = 0; k < 50 && xOffset != 6'd17; k++) wait_pulse(c);
        check("reach_x17", int'(xOffset), 17);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_x",     int'(xOffset),    0);
        check("async_y",     int'(yOffset),    0);
        check("async_clr",   int'(counterClr), 1);
        check("async_pulse", int'(stepPulse),  0);
        check("async_dir",   int'(dirLeft),    0);
        check("async_land",  int'(landed),     0);
        @(negedge clk);
        rst = 1'b1;

        pulse_start();
        for (int k = 0; k < 100 && xOffset != 6'd40; k++) wait_pulse(c);
        check("reach_x40", int'(xOffset), 40);
        wait_pulse(c);
        check("edge_hold_x", int'(xOffset), 40);
        check("edge_y",      int'(yOffset), 0);
        wait_pulse(c);
        check("drop_y",   int'(yOffset), 1);
        check("drop_dir", int'(dirLeft), 1);
        check("drop_x",   int'(xOffset), 40);
        wait_pulse(c);
        check("left_x", int'(xOffset), 39);

        // Freeze with the counter well past the period.
        enable = 1'b0;
        npulse = 0;
        repeat (10) begin
            @(negedge clk);
            npulse += int'(stepPulse);
        end
        check("frozen_pulses", npulse, 0);
        check("frozen_x", int'(xOffset), 39);
        enable = 1'b1;
        @(negedge clk);
        check("resume_pulse", int'(stepPulse), 1);
        check("resume_x",     int'(xOffset),  38);

        for (int k = 0; k < 300 && yOffset != 5'd3; k++) wait_pulse(c);
        check("reach_y3", int'(yOffset), 3);
        wait_pulse(c);
`ifdef MARCH_SPEEDUP_EN
        check("late_interval", c, 3);
`else
        check("late_interval", c, 5);
`endif

        for (int k = 0; k < 2000 && !landed; k++) wait_pulse(c);
        check("landed",      int'(landed),     1);
        check("land_y",      int'(yOffset),    20);
        check("land_x",      int'(xOffset),    0);
        check("land_dir",    int'(dirLeft),    0);
        check("land_clr",    int'(counterClr), 1);

        npulse = 0;
        nclr0 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = (k % 4 == 0);
            npulse += int'(stepPulse);
            nclr0  += int'(!counterClr);
        end
        start = 1'b0;
        check("landed_pulses", npulse, 0);
        check("landed_clr_low", nclr0, 0);
        check("landed_stays_y", int'(yOffset), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
